calc_stream_engine: RTL and testbench
=====================================

Name: calc_stream_engine

Overview:
Parametrised successor to the fixed 32-bit calculator datapath. It fuses sequencing, arithmetic and result packing into one block with selectable arithmetic modes and start/done control. It streams packed operand words from a synchronous-read memory over an inclusive address range, and computes one result per word (operand A in the upper half, operand B in the lower half). It packs two results per memory word and writes them to a bounded write range. It sits between the two-port SRAM pair and the top level.

Parameters:
DATA_W, 32, operand/result width; memory word is 2*DATA_W
ADDR_W, 9, memory address width

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse; starts a job when idle
mode_i  in  2  00 add wrap, 01 sub (A-B) wrap, 10 add unsigned saturate, 11 sub unsigned saturate (floor 0)
rd_start_addr_i  in  ADDR_W  first read address (inclusive)
rd_end_addr_i  in  ADDR_W  last read address (inclusive)
wr_start_addr_i  in  ADDR_W  first write address
wr_end_addr_i  in  ADDR_W  last permitted write address
rd_en_o  out  1  read strobe
rd_addr_o  out  ADDR_W  read address
rd_data_i  in  2*DATA_W  read data, valid the cycle after rd_en_o; [2*DATA_W-1:DATA_W]=A, [DATA_W-1:0]=B
wr_en_o  out  1  write strobe
wr_addr_o  out  ADDR_W  write address
wr_data_o  out  2*DATA_W  packed results: first result in lower half, second in upper half
busy_o  out  1  high from the cycle after start is accepted until DONE exits
done_o  out  1  one-cycle pulse at job end
err_o  out  2  bit0 read-range error, bit1 write-range overflow; held until next accepted start
carry_o  out  1  sticky: any operation carried out (add) or borrowed (sub); cleared on accepted start

Behaviour:
- Reset: state IDLE. All outputs 0: rd_en_o, wr_en_o, addresses, wr_data_o, busy_o, done_o, err_o, carry_o. Internal pack register and half pointer also 0. Reset mid-job aborts immediately with no further strobes.
- Start acceptance:
  - start_i is sampled in IDLE only; it is ignored while busy.
  - On acceptance, latch all four addresses and mode_i, clear err_o and carry_o, and select the lower half.
- FSM: IDLE -> RD -> CALC -> (RD | WR) -> ... -> DONE -> IDLE.
- Range check at acceptance: if rd_end < rd_start, go straight to DONE with err_o[0]=1. No rd/wr strobes are issued.
- RD (1 cycle): rd_en_o=1, rd_addr_o=current read address.
- CALC (1 cycle): consume rd_data_i and compute the result per the latched mode. Store it in the selected half, then toggle the half.
  - Lower half just filled and more reads remain: next state RD at address+1.
  - Upper half just filled, or last read done: next state WR.
- WR (1 cycle): the write is issued only if write address <= wr_end.
  - If issued: wr_en_o=1, wr_addr_o=write address, wr_data_o=packed word. On an odd tail the upper half is 0.
  - Then clear the pack register, increment the write address, and go to RD if reads remain, else DONE.
  - If the write address exceeds wr_end: no strobe, err_o[1]=1, go to DONE. Remaining reads are abandoned.
- DONE (1 cycle): done_o=1, busy_o=1; next state IDLE.
- Arithmetic:
  - Wrap modes keep the result modulo 2^DATA_W.
  - Mode 10 clamps to all-ones on carry. Mode 11 clamps to 0 on borrow.
  - carry_o is set on carry or borrow in any mode.
- rd_en_o and wr_en_o are never high in the same cycle. Each is low outside RD/WR.
- Timing example: start sampled in cycle 0; N=2 reads gives RD c1, CALC c2, RD c3, CALC c4, WR c5, DONE c6. Total is 5 cycles per pair plus 1.
- Addresses do not wrap: rd_end = 2^ADDR_W-1 is legal and the counter stops at it.

Test Plan:
1. Add, DATA_W=32, rd 0..1 = {A=5,B=7},{A=0xFFFFFFFF,B=1}, wr 16..16 -> one write @16 data {0x00000000,0x0000000C}, carry_o=1, done_o in cycle 6, err_o=0.
2. Mode 11, rd 4..6 = {3,5},{9,2},{1,1}, wr 8..9 -> @8 {0x7,0x0}, @9 {0x0,0x0} (odd tail upper half 0), carry_o=1, 2 writes total.
3. Mode 10 {0xFFFFFFF0,0x20} -> lower result 0xFFFFFFFF; mode 00, same data -> 0x00000010; carry_o=1 in both.
4. rd_start=10, rd_end=9 -> no rd_en/wr_en ever, done_o one cycle after acceptance, err_o=01.
5. rd 0..5 (3 pairs), wr 20..21 -> writes @20, @21 only; third WR suppressed, err_o=10, no reads past addr 5.
6. start_i pulsed again mid-job ignored; rst_i asserted during CALC -> next cycle all outputs 0, IDLE, new start runs cleanly from scratch.

Source files
------------

// File: rtl/calc_stream_engine.sv
// Streams packed A/B operand words from memory, applies the selected add/sub mode and
// writes two results per packed output word to a bounded write range.
module calc_stream_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [ADDR_W-1:0]   rd_start_addr_i,
    input  logic [ADDR_W-1:0]   rd_end_addr_i,
    input  logic [ADDR_W-1:0]   wr_start_addr_i,
    input  logic [ADDR_W-1:0]   wr_end_addr_i,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic [2*DATA_W-1:0] rd_data_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [2*DATA_W-1:0] wr_data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          err_o,
    output logic                carry_o
);

    typedef enum logic [2:0] {StIdle, StRd, StCalc, StWr, StDone} state_e;

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   rd_end_q;
    logic [ADDR_W-1:0]   wr_end_q;
    logic [ADDR_W:0]     wr_ptr_q;  // extra bit so the pointer never wraps past the top
    logic [2*DATA_W-1:0] pack_q;
    logic                half_q;

    logic [DATA_W-1:0]   opa, opb, res;
    logic [DATA_W:0]     sum, diff;
    logic                cy;
    logic [2*DATA_W-1:0] pack_nxt;
    logic                rd_last;
    logic                wr_ok;

    always_comb begin
        opa  = rd_data_i[2*DATA_W-1:DATA_W];
        opb  = rd_data_i[DATA_W-1:0];
        sum  = {1'b0, opa} + {1'b0, opb};
        diff = {1'b0, opa} - {1'b0, opb};
        cy   = mode_q[0] ? diff[DATA_W] : sum[DATA_W];
        res  = '0;
        unique case (mode_q)
            2'b00: res = sum[DATA_W-1:0];
            2'b01: res = diff[DATA_W-1:0];
            2'b10: res = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
            2'b11: res = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
            default: res = '0;
        endcase
        pack_nxt = half_q ? {res, pack_q[DATA_W-1:0]} : {pack_q[2*DATA_W-1:DATA_W], res};
        rd_last  = (rd_addr_o == rd_end_q);
        wr_ok    = (wr_ptr_q <= {1'b0, wr_end_q});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            rd_end_q  <= '0;
            wr_end_q  <= '0;
            wr_ptr_q  <= '0;
            pack_q    <= '0;
            half_q    <= 1'b0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= '0;
            carry_o   <= 1'b0;
        end else begin
            rd_en_o <= 1'b0;
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        rd_end_q  <= rd_end_addr_i;
                        wr_end_q  <= wr_end_addr_i;
                        wr_ptr_q  <= {1'b0, wr_start_addr_i};
                        rd_addr_o <= rd_start_addr_i;
                        pack_q    <= '0;
                        half_q    <= 1'b0;
                        err_o     <= '0;
                        carry_o   <= 1'b0;
                        busy_o    <= 1'b1;
                        if (rd_end_addr_i < rd_start_addr_i) begin
                            err_o   <= 2'b01;
                            done_o  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            rd_en_o <= 1'b1;
                            state_q <= StRd;
                        end
                    end
                end
                StRd: state_q <= StCalc;
                StCalc: begin
                    pack_q  <= pack_nxt;
                    half_q  <= ~half_q;
                    carry_o <= carry_o | cy;
                    if (!half_q && !rd_last) begin
                        rd_addr_o <= rd_addr_o + 1'b1;
                        rd_en_o   <= 1'b1;
                        state_q   <= StRd;
                    end else begin
                        wr_en_o   <= wr_ok;
                        wr_addr_o <= wr_ptr_q[ADDR_W-1:0];
                        wr_data_o <= pack_nxt;
                        state_q   <= StWr;
                    end
                end
                StWr: begin
                    if (wr_ok) begin
                        pack_q   <= '0;
                        half_q   <= 1'b0;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (rd_last) begin
                            done_o  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            rd_addr_o <= rd_addr_o + 1'b1;
                            rd_en_o   <= 1'b1;
                            state_q   <= StRd;
                        end
                    end else begin
                        // Write range exhausted: abandon any remaining reads.
                        err_o[1] <= 1'b1;
                        done_o   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_stream_engine.sv
// Directed bench for calc_stream_engine: a job-level reference model predicts reads, writes,
// flags and done timing; a per-cycle monitor compares the DUT against it.
module tb_calc_stream_engine;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_i, start_i;
    logic [1:0]    mode_i;
    logic [AW-1:0] rd_start_addr_i, rd_end_addr_i, wr_start_addr_i, wr_end_addr_i;
    logic          rd_en_o, wr_en_o, busy_o, done_o, carry_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [63:0]   rd_data_i, wr_data_o;
    logic [1:0]    err_o;

    calc_stream_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .rd_start_addr_i(rd_start_addr_i), .rd_end_addr_i(rd_end_addr_i),
        .wr_start_addr_i(wr_start_addr_i), .wr_end_addr_i(wr_end_addr_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .carry_o(carry_o)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:511];
    always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    int          exp_rd[$];
    int          exp_wr_addr[$];
    logic [63:0] exp_wr_data[$];
    logic [1:0]  exp_err;
    logic        exp_carry;
    int          exp_done;

    task automatic op(input logic [1:0] m, input longint unsigned a, input longint unsigned b,
                      output logic [31:0] r, output logic c);
        longint unsigned full;
        if (m[0] == 1'b0) begin
            full = a + b;
            c    = (full > 64'h0000_0000_FFFF_FFFF);
            r    = (c && m[1]) ? 32'hFFFF_FFFF : full[31:0];
        end else begin
            c = (a < b);
            r = (c && m[1]) ? 32'h0 : 32'(a - b);
        end
    endtask

    task automatic model_job(input int rs, input int re, input int ws, input int we,
                             input logic [1:0] m);
        int a, w, n;
        logic [31:0] lo, hi, r;
        logic c;
        exp_rd.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
        exp_err = 2'b00; exp_carry = 1'b0; exp_done = 1;
        if (re < rs) begin
            exp_err = 2'b01;
            return;
        end
        a = rs; w = ws;
        forever begin
            n = (re - a + 1 >= 2) ? 2 : 1;
            lo = '0; hi = '0;
            for (int j = 0; j < n; j++) begin
                exp_rd.push_back(a + j);
                op(m, longint'(mem[a+j][63:32]), longint'(mem[a+j][31:0]), r, c);
                exp_carry |= c;
                if (j == 0) lo = r; else hi = r;
            end
            exp_done += 2 * n + 1;
            if (w > we) begin
                exp_err = 2'b10;
                break;
            end
            exp_wr_addr.push_back(w);
            exp_wr_data.push_back({hi, lo});
            w++;
            a += n;
            if (a > re) break;
        end
    endtask

    // Monitor
    logic        mon_on = 1'b0;
    int          cyc;
    int          nrd, nwr;
    logic [63:0] first_wr_data, last_wr_data;
    int          last_wr_addr;

    always @(negedge clk) if (mon_on) begin
        chk("rd_wr_exclusive", rd_en_o & wr_en_o, 0);
        chk("done_pulse", done_o, cyc == exp_done);
        chk("busy", busy_o, cyc <= exp_done);
        if (rd_en_o) begin
            nrd++;
            if (exp_rd.size() == 0) chk("rd_extra", rd_addr_o, 64'hFFFF);
            else chk("rd_addr", rd_addr_o, exp_rd.pop_front());
        end
        if (wr_en_o) begin
            if (nwr == 0) first_wr_data = wr_data_o;
            nwr++;
            last_wr_addr = wr_addr_o;
            last_wr_data = wr_data_o;
            if (exp_wr_addr.size() == 0) chk("wr_extra", wr_addr_o, 64'hFFFF);
            else begin
                chk("wr_addr", wr_addr_o, exp_wr_addr.pop_front());
                chk("wr_data", wr_data_o, exp_wr_data.pop_front());
            end
        end
        if (cyc == exp_done) begin
            chk("err", err_o, exp_err);
            chk("carry", carry_o, exp_carry);
            chk("rd_missing", exp_rd.size(), 0);
            chk("wr_missing", exp_wr_addr.size(), 0);
        end
    end

    task automatic run_job(input int rs, input int re, input int ws, input int we,
                           input logic [1:0] m, input int poke);
        model_job(rs, re, ws, we, m);
        nrd = 0; nwr = 0; first_wr_data = '0; last_wr_data = '0; last_wr_addr = -1;
        @(posedge clk); #1;
        rd_start_addr_i = AW'(rs); rd_end_addr_i = AW'(re);
        wr_start_addr_i = AW'(ws); wr_end_addr_i = AW'(we);
        mode_i = m; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 1;
        mon_on = 1'b1;
        while (cyc <= exp_done + 1) begin
            if (cyc == poke) begin
                start_i = 1'b1;
                mode_i = ~m;
                rd_start_addr_i = '0; rd_end_addr_i = '1;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            cyc++;
        end
        mon_on = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, busy_o, done_o, err_o, carry_o}, 0);
        chk({name, "_wdata"}, wr_data_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {32'(i * 3 + 1), 32'(i * 7 + 2)};
        rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00;
        rd_start_addr_i = '0; rd_end_addr_i = '0; wr_start_addr_i = '0; wr_end_addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        rst_i = 1'b0;

        // 1: add wrap, one packed write, done in cycle 6
        mem[0] = {32'd5, 32'd7};
        mem[1] = {32'hFFFF_FFFF, 32'd1};
        run_job(0, 1, 16, 16, 2'b00, -1);
        chk("t1_done_cycle", exp_done, 6);
        chk("t1_nwr", nwr, 1);
        chk("t1_addr", last_wr_addr, 16);
        chk("t1_data", last_wr_data, 64'h0000_0000_0000_000C);
        chk("t1_carry", carry_o, 1);
        chk("t1_err", err_o, 0);

        // 2: sub saturate with odd tail
        mem[4] = {32'd3, 32'd5};
        mem[5] = {32'd9, 32'd2};
        mem[6] = {32'd1, 32'd1};
        run_job(4, 6, 8, 9, 2'b11, -1);
        chk("t2_nwr", nwr, 2);
        chk("t2_first", first_wr_data, 64'h0000_0007_0000_0000);
        chk("t2_last_addr", last_wr_addr, 9);
        chk("t2_last", last_wr_data, 64'h0);
        chk("t2_carry", carry_o, 1);

        // 3: add saturate vs add wrap on the same operands
        mem[7] = {32'hFFFF_FFF0, 32'h20};
        run_job(7, 7, 10, 10, 2'b10, -1);
        chk("t3_sat", last_wr_data, 64'h0000_0000_FFFF_FFFF);
        chk("t3_sat_carry", carry_o, 1);
        run_job(7, 7, 11, 11, 2'b00, -1);
        chk("t3_wrap", last_wr_data, 64'h0000_0000_0000_0010);
        chk("t3_wrap_carry", carry_o, 1);

        // 4: empty read range
        run_job(10, 9, 0, 5, 2'b00, -1);
        chk("t4_nrd", nrd, 0);
        chk("t4_nwr", nwr, 0);
        chk("t4_err", err_o, 2'b01);

        // 5: write range overflow on the third pair
        run_job(0, 5, 20, 21, 2'b00, -1);
        chk("t5_nwr", nwr, 2);
        chk("t5_nrd", nrd, 6);
        chk("t5_last_addr", last_wr_addr, 21);
        chk("t5_err", err_o, 2'b10);

        // Top-of-memory read and write boundaries
        run_job(510, 511, 511, 511, 2'b01, -1);
        chk("top_nwr", nwr, 1);

        // 6: restart pulse mid-job is ignored
        run_job(0, 5, 30, 40, 2'b01, 3);
        chk("t6_nwr", nwr, 3);

        // 6b: reset during CALC aborts the job
        @(posedge clk); #1;
        rd_start_addr_i = 9'd0; rd_end_addr_i = 9'd5;
        wr_start_addr_i = 9'd50; wr_end_addr_i = 9'd60;
        mode_i = 2'b00; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("t6_rd_strobe", rd_en_o, 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk_all_zero("t6_after_reset");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("t6_quiet", {rd_en_o, wr_en_o, busy_o, done_o}, 0);
        end
        run_job(2, 4, 70, 71, 2'b00, -1);
        chk("t6_clean_nwr", nwr, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of stimulus");
        $fatal(1);
    end

endmodule
